// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding and bit-timing derivation.
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small received-byte FIFO; the head byte is held in a register so it stays stable when empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_do_push = push & (~full | w_do_pop);
  assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_do_push};
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_do_pop};
  assign dout      = r_dout;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      // Preload the next head; bypass when it is the byte being written this cycle.
      if (w_rd_next != w_wr_next) begin
        r_dout <= (w_do_push && (w_rd_next == r_wr_ptr)) ? din : r_mem[w_rd_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, shifter and output FIFO.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 1000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_rate
      $error("uart_rx_8n1: CLK_FREQ/BAUD must be at least 8");
    end
  endgenerate

  uart_state_t   r_state;
  logic          r_rx_meta;
  logic          r_rxs;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_stop_wait;
  logic          r_frame_err;
  logic          r_overrun;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  assign w_push    = (r_state == ST_STOP) && !r_stop_wait && (r_timer == BIT_LAST) && r_rxs;
  assign out_valid = ~w_empty;
  assign w_pop     = out_ready & out_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_stop_wait <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= w_push & w_full & ~w_pop;
      case (r_state)
        ST_IDLE: begin
          if (!r_rxs) begin
            r_state <= ST_START;
            r_timer <= '0;
          end
        end
        ST_START: begin
          if (r_timer == HALF_LAST) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_state   <= r_rxs ? ST_IDLE : ST_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_timer == BIT_LAST) begin
            r_timer   <= '0;
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state     <= ST_STOP;
              r_stop_wait <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_STOP: begin
          // After a bad stop bit, hold here until the line returns to idle.
          if (r_stop_wait) begin
            if (r_rxs) begin
              r_state     <= ST_IDLE;
              r_stop_wait <= 1'b0;
            end
          end else if (r_timer == BIT_LAST) begin
            r_timer <= '0;
            if (r_rxs) begin
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_stop_wait <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (w_push),
    .din  (r_shift),
    .pop  (w_pop),
    .full (w_full),
    .empty(w_empty),
    .dout (out_data)
  );

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: frame-level byte model plus literal per-test expectations.
module tb_uart_rx_8n1;

  localparam int CPB   = 100;
  localparam int CPB2  = 868;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, frame_err, overrun, busy;

  logic       rx2 = 1'b1;
  logic       out_ready2 = 1'b1;
  logic [7:0] out_data2;
  logic       out_valid2, frame_err2, overrun2, busy2;

  always #5 clk = ~clk;

  uart_rx_8n1 #(.CLK_FREQ(100000000), .BAUD(1000000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_8n1 #(.CLK_FREQ(100000000), .BAUD(115200), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .frame_err(frame_err2), .overrun(overrun2), .busy(busy2)
  );

  int errors = 0;
  int checks = 0;
  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  byte unsigned exp_q2[$];
  byte unsigned got_q2[$];
  int ferr_pend = 0, ovr_pend = 0;
  int n_valid = 0, n_ferr = 0, n_ovr = 0, n_busy = 0;
  byte unsigned m_b1, m_b2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  // Frame-level model: what the receiver must deliver once a complete frame is on the line.
  task automatic model_frame(input bit sel, input byte unsigned b, input bit good);
    if (!good)                      ferr_pend++;
    else if (sel)                   exp_q2.push_back(b);
    else if (exp_q.size() >= DEPTH) ovr_pend++;
    else                            exp_q.push_back(b);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input bit good, input int low_cycles);
    int cpb;
    cpb = sel ? CPB2 : CPB;
    set_rx(sel, 1'b0);
    wait_clks(cpb);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      wait_clks(cpb);
    end
    model_frame(sel, b, good);
    if (!good) begin
      set_rx(sel, 1'b0);
      wait_clks(low_cycles);
    end
    set_rx(sel, 1'b1);
    wait_clks(cpb);
    $display("frame dut%0d byte=0x%02h stop=%s", sel ? 2 : 1, b, good ? "ok" : "low");
  endtask

  task automatic check_got(input string name, input bit sel, input int n, input logic [31:0] bytes);
    if (sel) begin
      chk({name, "_count"}, got_q2.size(), n);
      for (int i = 0; i < n && i < got_q2.size(); i++)
        chk({name, "_byte"}, got_q2[i], bytes[8*i +: 8]);
      got_q2.delete();
    end else begin
      chk({name, "_count"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++)
        chk({name, "_byte"}, got_q[i], bytes[8*i +: 8]);
      got_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) n_busy++;
      if (frame_err) begin
        n_ferr++;
        chk("frame_err_expected", (ferr_pend > 0) ? 1 : 0, 1);
        if (ferr_pend > 0) ferr_pend--;
      end
      if (overrun) begin
        n_ovr++;
        chk("overrun_expected", (ovr_pend > 0) ? 1 : 0, 1);
        if (ovr_pend > 0) ovr_pend--;
      end
      if (out_valid) begin
        n_valid++;
        chk("valid_has_model_byte", (exp_q.size() > 0) ? 1 : 0, 1);
        if (out_ready && exp_q.size() > 0) begin
          m_b1 = exp_q.pop_front();
          chk("pop_data", out_data, m_b1);
          got_q.push_back(out_data);
        end
      end
      if (out_valid2) begin
        chk("valid2_has_model_byte", (exp_q2.size() > 0) ? 1 : 0, 1);
        if (exp_q2.size() > 0) begin
          m_b2 = exp_q2.pop_front();
          chk("pop2_data", out_data2, m_b2);
        end
        got_q2.push_back(out_data2);
      end
      chk("dut2_no_frame_err", frame_err2, 0);
      chk("dut2_no_overrun", overrun2, 0);
    end
  end

  initial begin
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(2);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy2", busy2, 0);

    // Single byte with consumer ready.
    out_ready = 1'b1;
    n_valid = 0; n_ferr = 0; n_ovr = 0;
    send_frame(0, 8'h41, 1, 0);
    wait_clks(20);
    check_got("byte41", 0, 1, 32'h41);
    chk("byte41_valid_cycles", n_valid, 1);
    chk("byte41_frame_err", n_ferr, 0);
    chk("byte41_overrun", n_ovr, 0);
    chk("byte41_data_held", out_data, 8'h41);
    chk("byte41_valid_low", out_valid, 0);

    // 300 ns glitch must be rejected at the half-bit check.
    n_valid = 0; n_busy = 0; n_ferr = 0;
    rx = 1'b0;
    wait_clks(30);
    rx = 1'b1;
    wait_clks(200);
    $display("glitch 300ns busy_cycles=%0d", n_busy);
    chk("glitch_busy_seen", (n_busy > 0) ? 1 : 0, 1);
    chk("glitch_busy_short", (n_busy < CPB) ? 1 : 0, 1);
    chk("glitch_no_push", n_valid, 0);
    chk("glitch_no_frame_err", n_ferr, 0);
    chk("glitch_idle", busy, 0);

    // Bad stop bit, then recovery.
    n_valid = 0; n_ferr = 0;
    send_frame(0, 8'hA5, 0, 200);
    wait_clks(20);
    chk("ferr_pulses", n_ferr, 1);
    chk("ferr_no_push", n_valid, 0);
    chk("ferr_idle", busy, 0);
    send_frame(0, 8'h3C, 1, 0);
    wait_clks(20);
    check_got("after_ferr", 0, 1, 32'h3C);

    // Fill the FIFO with the consumer stalled; fifth byte overruns.
    out_ready = 1'b0;
    n_ovr = 0;
    for (int i = 0; i < 5; i++) send_frame(0, 8'(i), 1, 0);
    wait_clks(20);
    chk("ovr_pulses", n_ovr, 1);
    chk("ovr_valid_held", out_valid, 1);
    chk("ovr_head", out_data, 8'h00);
    out_ready = 1'b1;
    wait_clks(20);
    check_got("ovr_drain", 0, 4, 32'h03020100);
    chk("ovr_drained_valid", out_valid, 0);

    // Reset during bit 4 of 0xFF, released at bit 6.
    rx = 1'b0;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(4 * CPB);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_valid", out_valid, 0);
    chk("midreset_data", out_data, 8'h00);
    wait_clks(2 * CPB);
    rst_n = 1'b1;
    wait_clks(3 * CPB);
    $display("frame dut1 byte=0xff abandoned by reset");
    chk("postreset_idle", busy, 0);
    check_got("postreset_nopush", 0, 0, 32'h0);
    send_frame(0, 8'h52, 1, 0);
    wait_clks(20);
    check_got("after_reset", 0, 1, 32'h52);

    // Back-to-back frames at both rates.
    send_frame(0, 8'h55, 1, 0);
    send_frame(0, 8'hAA, 1, 0);
    wait_clks(20);
    check_got("b2b_1M", 0, 2, 32'hAA55);
    send_frame(1, 8'h55, 1, 0);
    send_frame(1, 8'hAA, 1, 0);
    wait_clks(50);
    check_got("b2b_115200", 1, 2, 32'hAA55);

    chk("final_ferr_pending", ferr_pend, 0);
    chk("final_ovr_pending", ovr_pend, 0);
    chk("final_model_empty", exp_q.size(), 0);
    chk("final_model2_empty", exp_q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 1000000, line bit rate in bit/s (1000 ns per bit).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer depth; power of two, 2..16.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-007 SHALL have port out_data, output, 8, byte at FIFO head.
REQ-008 SHALL have port out_valid, output, 1, high while the FIFO is not empty.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the byte; pop occurs when out_valid and out_ready are both high.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL compute CLKS_PER_BIT = CLK_FREQ/BAUD (integer), giving 100 at defaults; elaboration SHALL fail if the result is < 8.
REQ-014 SHALL pass rx through a 2-flop synchronizer preset to 1; all decisions use the synchronized value rxs.
REQ-015 SHALL implement an FSM with states IDLE, START, DATA, STOP.
REQ-016 IDLE: on rxs = 0, go to START and clear the bit timer.
REQ-017 START: at timer = CLKS_PER_BIT/2 - 1, sample rxs. If 0, go to DATA and restart the timer. If 1, treat it as a glitch and return to IDLE with no pulse.
REQ-018 DATA: every CLKS_PER_BIT cycles, sample rxs into a shift register, LSB first. After the 8th sample, go to STOP.
REQ-019 STOP: sample at one full bit period. If 1, push the byte and return to IDLE. If 0, pulse frame_err for one cycle, discard the byte, and wait in STOP until rxs = 1 before entering IDLE.
REQ-020 Push latency: out_valid SHALL rise in the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-021 FIFO full on push, no pop in the same cycle: drop the byte, pulse overrun, and leave contents unchanged.
REQ-022 FIFO full, push and pop in the same cycle: both SHALL occur, with no overrun.
REQ-023 FIFO empty: out_valid = 0 and out_ready is ignored. out_data is don't-care but SHALL hold its last value.
REQ-024 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty are decoded from the MSB difference.
REQ-025 A new start bit SHALL be accepted in the cycle immediately after the return to IDLE; back-to-back frames SHALL be received with no lost bytes.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, synchronizer flops 1, timer 0, shift register 0, FIFO pointers 0, out_valid 0, out_data 0x00, frame_err 0, overrun 0, busy 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame. After release, the FSM SHALL wait in IDLE for the next falling edge, and a frame already in progress on the line SHALL NOT produce a push.
REQ-028 Reset release SHALL be synchronized externally; the block SHALL not need a reset-deassertion synchronizer.

Structure
REQ-029 SHALL place the FSM state encoding and the CLKS_PER_BIT/half-bit derivation in shared package uart_pkg, reused by the planned uart_tx.
REQ-030 SHALL implement the FIFO as sub-module uart_rx_fifo (parameters WIDTH and DEPTH, ports push/pop/full/empty/dout); the FSM, timer, and shifter stay in uart_rx_8n1.

Verification
REQ-031 Send 0x41 (LSB first, 1000 ns/bit) with out_ready = 1 -> out_data = 0x41 and out_valid high for 1 cycle; frame_err = 0, overrun = 0.
REQ-032 Drive rx low for 300 ns, then high -> no push, no frame_err, busy high less than 1 us.
REQ-033 Send 0xA5 with the stop bit held low for 2 us -> frame_err exactly one pulse, out_valid stays 0; a following 0x3C is received correctly.
REQ-034 Hold out_ready = 0 and send 0x00, 0x01, 0x02, 0x03, 0x04 -> overrun pulses once (on 0x04). Then raise out_ready -> pops 0x00, 0x01, 0x02, 0x03 in order, after which out_valid = 0.
REQ-035 Assert rst_n low at bit 4 of 0xFF, release at bit 6 -> no push for that frame; the next 0x52 is received correctly.
REQ-036 Send 0x55 then 0xAA back-to-back (no idle gap) at CLK_FREQ = 100 MHz and BAUD = 1000000 -> both bytes received in order; repeat with BAUD = 115200 and the bit period matched accordingly.
